// File: rtl/mul_err_pkg.sv
// Shared widths, FSM state type and saturating-add helpers for the multiplier error-statistics block.
package mul_err_pkg;

    localparam int PROD_W_DEF = 32;
    localparam int ACC_W_DEF  = 64;
    localparam int CNT_W_DEF  = 32;
    localparam int SAT_W      = 128;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    // Operands are zero-extended to SAT_W by the caller; the result clamps at 2^w-1.
    function automatic logic [SAT_W-1:0] sat_add_u(input logic [SAT_W-1:0] a,
                                                   input logic [SAT_W-1:0] b,
                                                   input int unsigned      w);
        logic [SAT_W-1:0] lim;
        logic [SAT_W-1:0] s;
        lim = {SAT_W{1'b1}} >> (SAT_W - w);
        s   = a + b;
        return (s > lim) ? lim : s;
    endfunction

    // Operands are sign-extended to SAT_W by the caller; the result clamps to the w-bit signed range.
    function automatic logic signed [SAT_W-1:0] sat_add_s(input logic signed [SAT_W-1:0] a,
                                                          input logic signed [SAT_W-1:0] b,
                                                          input int unsigned             w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] s;
        hi = $signed({SAT_W{1'b1}} >> (SAT_W - w + 1));
        lo = ~hi;
        s  = a + b;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/err_stats_pipe.sv
// Error-statistics datapath: capture, scale/subtract, square/accumulate.
// Latency: sample captured on edge k, accumulators reflect it after edge k+2.
// Backpressure: none; always accepts acc_vld, pipe_busy flags an occupied capture stage.
// ERR_MAX_TRACK_EN adds the max_abs_err tracker.
module err_stats_pipe
    import mul_err_pkg::*;
#(
    parameter int PROD_W      = PROD_W_DEF,
    parameter int SHIFT_WIDTH = 8,
    parameter int ACC_W       = ACC_W_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              acc_vld,
    input  logic [PROD_W-1:0] appr_prod,
    input  logic [PROD_W-1:0] prec_prod,
    output logic              pipe_busy,
    output logic [ACC_W-1:0]  sum_err,
    output logic [ACC_W-1:0]  sum_sq_err,
    output logic [ACC_W-1:0]  sum_abs_prec,
    output logic [CNT_W-1:0]  same_cnt
`ifdef ERR_MAX_TRACK_EN
    ,
    output logic [PROD_W:0]   max_abs_err
`endif
);

    logic                     v0_q, v1_q;
    logic signed [PROD_W-1:0] appr_q, prec_q;
    logic signed [PROD_W-1:0] a_s, p_s;
    logic signed [PROD_W:0]   err_s, err_q;
    logic [PROD_W-1:0]        absp_s, absp_q;
    logic                     eq_q;
    logic signed [2*PROD_W+1:0] sq;
    logic signed [SAT_W-1:0]  err_raw, err_nxt;
    logic                     err_sat_q;

    assign a_s    = appr_q >>> SHIFT_WIDTH;
    assign p_s    = prec_q >>> SHIFT_WIDTH;
    assign err_s  = $signed({a_s[PROD_W-1], a_s}) - $signed({p_s[PROD_W-1], p_s});
    assign absp_s = p_s[PROD_W-1] ? $unsigned(-p_s) : $unsigned(p_s);
    assign sq     = err_q * err_q;

    assign err_raw = SAT_W'($signed(sum_err)) + SAT_W'(err_q);
    assign err_nxt = sat_add_s(SAT_W'($signed(sum_err)), SAT_W'(err_q), ACC_W);

    assign pipe_busy = v0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
            appr_q <= '0;
            prec_q <= '0;
            err_q  <= '0;
            absp_q <= '0;
            eq_q   <= 1'b0;
        end else begin
            v0_q <= acc_vld && !clr;
            v1_q <= v0_q && !clr;
            if (acc_vld) begin
                appr_q <= $signed(appr_prod);
                prec_q <= $signed(prec_prod);
            end
            if (v0_q) begin
                err_q  <= err_s;
                absp_q <= absp_s;
                eq_q   <= (err_s == '0);
            end
        end
    end

    // Signed sum can move back toward zero, so its saturation is held by an explicit flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_err      <= '0;
            err_sat_q    <= 1'b0;
            sum_sq_err   <= '0;
            sum_abs_prec <= '0;
            same_cnt     <= '0;
        end else if (clr) begin
            sum_err      <= '0;
            err_sat_q    <= 1'b0;
            sum_sq_err   <= '0;
            sum_abs_prec <= '0;
            same_cnt     <= '0;
        end else if (v1_q) begin
            if (!err_sat_q) begin
                sum_err   <= ACC_W'(err_nxt);
                err_sat_q <= (err_nxt != err_raw);
            end
            sum_sq_err   <= ACC_W'(sat_add_u(SAT_W'(sum_sq_err), SAT_W'($unsigned(sq)), ACC_W));
            sum_abs_prec <= ACC_W'(sat_add_u(SAT_W'(sum_abs_prec), SAT_W'(absp_q), ACC_W));
            same_cnt     <= same_cnt + CNT_W'(eq_q);
        end
    end

`ifdef ERR_MAX_TRACK_EN
    logic [PROD_W:0] abs_err;
    assign abs_err = err_q[PROD_W] ? $unsigned(-err_q) : $unsigned(err_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           max_abs_err <= '0;
        else if (clr)                         max_abs_err <= '0;
        else if (v1_q && abs_err > max_abs_err) max_abs_err <= abs_err;
    end
`endif

endmodule

// File: rtl/mul_err_stats.sv
// Approximate-multiplier error statistics over a programmed sample count (ERR_MAX_TRACK_EN adds max_abs_err).
// Latency: sample accepted on edge k appears in the sums after edge k+2; done rises with the final update.
// Backpressure: in_ready from state/counter only; drops after n_samples accepts and outside RUN.
module mul_err_stats
    import mul_err_pkg::*;
#(
    parameter int PROD_W      = PROD_W_DEF,
    parameter int SHIFT_WIDTH = 8,
    parameter int ACC_W       = ACC_W_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_samples,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] appr_prod,
    input  logic [PROD_W-1:0] prec_prod,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  sum_err,
    output logic [ACC_W-1:0]  sum_sq_err,
    output logic [ACC_W-1:0]  sum_abs_prec,
    output logic [CNT_W-1:0]  same_cnt
`ifdef ERR_MAX_TRACK_EN
    ,
    output logic [PROD_W:0]   max_abs_err
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, target_q;
    logic             accept, start_ok, pipe_busy;

    assign in_ready = (state_q == RUN) && (cnt_q < target_q);
    assign accept   = in_valid && in_ready;
    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                cnt_q    <= '0;
                target_q <= n_samples;
            end else if (accept) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // DRAIN exits once the capture stage is empty: the last sample's accumulate happens on that same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN: begin
                if (cnt_q >= target_q)                              state_d = DONE;
                else if (accept && (cnt_q == target_q - CNT_W'(1))) state_d = DRAIN;
            end
            DRAIN: if (!pipe_busy) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    err_stats_pipe #(
        .PROD_W      (PROD_W),
        .SHIFT_WIDTH (SHIFT_WIDTH),
        .ACC_W       (ACC_W),
        .CNT_W       (CNT_W)
    ) u_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (start_ok),
        .acc_vld      (accept),
        .appr_prod    (appr_prod),
        .prec_prod    (prec_prod),
        .pipe_busy    (pipe_busy),
        .sum_err      (sum_err),
        .sum_sq_err   (sum_sq_err),
        .sum_abs_prec (sum_abs_prec),
        .same_cnt     (same_cnt)
`ifdef ERR_MAX_TRACK_EN
        ,
        .max_abs_err  (max_abs_err)
`endif
    );

endmodule

// File: tb/tb_mul_err_stats.sv
// Directed self-checking bench for mul_err_stats (accumulators at 40 bits to reach saturation quickly).
module tb_mul_err_stats;

    localparam int ACC_W = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] n_samples;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] appr_prod;
    logic [31:0] prec_prod;
    logic        busy;
    logic        done;
    logic [ACC_W-1:0] sum_err;
    logic [ACC_W-1:0] sum_sq_err;
    logic [ACC_W-1:0] sum_abs_prec;
    logic [31:0] same_cnt;
`ifdef ERR_MAX_TRACK_EN
    logic [32:0] max_abs_err;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mul_err_stats #(.PROD_W(32), .SHIFT_WIDTH(8), .ACC_W(ACC_W), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .n_samples    (n_samples),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .appr_prod    (appr_prod),
        .prec_prod    (prec_prod),
        .busy         (busy),
        .done         (done),
        .sum_err      (sum_err),
        .sum_sq_err   (sum_sq_err),
        .sum_abs_prec (sum_abs_prec),
        .same_cnt     (same_cnt)
`ifdef ERR_MAX_TRACK_EN
        ,
        .max_abs_err  (max_abs_err)
`endif
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_sums(input string tag, input longint e_err, input longint e_sq,
                            input longint e_abs, input longint e_same);
        chk({tag, "_sum_err"},   longint'($signed(sum_err)), e_err);
        chk({tag, "_sum_sq"},    longint'(sum_sq_err),       e_sq);
        chk({tag, "_sum_abs"},   longint'(sum_abs_prec),     e_abs);
        chk({tag, "_same_cnt"},  longint'(same_cnt),         e_same);
    endtask

    // All tasks begin and end at a falling edge.
    task automatic do_start(input logic [31:0] n);
        start     = 1'b1;
        n_samples = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] p);
        logic ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        appr_prod = a;
        prec_prod = p;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", longint'(ok), 1);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int xfers;
        rst_n     = 1'b0;
        start     = 1'b0;
        n_samples = '0;
        in_valid  = 1'b0;
        appr_prod = '0;
        prec_prod = '0;
        cycles(2);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_busy",     longint'(busy),     0);
        chk("rst_done",     longint'(done),     0);
        chk_sums("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        cycles(1);

        // Basic run: errors 2,-2,0,-2 ; |p| 1,3,5,1
        do_start(4);
        chk("t1_busy",     longint'(busy),     1);
        chk("t1_in_ready", longint'(in_ready), 1);
        send(32'h0000_0300, 32'h0000_0100);
        send(32'h0000_0100, 32'h0000_0300);
        send(32'h0000_0500, 32'h0000_0500);
        send(32'hFFFF_FF00, 32'h0000_0100);
        chk("t1_done_k0",  longint'(done),     0);
        chk("t1_rdy_low",  longint'(in_ready), 0);
        cycles(1);
        chk("t1_done_k1",  longint'(done),     0);
        chk("t1_part_sq",  longint'(sum_sq_err), 8);
        cycles(1);
        chk("t1_done_k2",  longint'(done),     1);
        chk("t1_busy_end", longint'(busy),     0);
        chk_sums("t1", -2, 12, 10, 1);
        cycles(2);
        chk_sums("t1_hold", -2, 12, 10, 1);

        // Zero-length run
        do_start(0);
        chk_sums("t2_clr", 0, 0, 0, 0);
        chk("t2_done0",   longint'(done),     0);
        chk("t2_rdy0",    longint'(in_ready), 0);
        cycles(1);
        chk("t2_done1",   longint'(done),     1);
        chk("t2_rdy1",    longint'(in_ready), 0);

        // Toggling valid, plus a start while busy that must be ignored
        do_start(3);
        xfers     = 0;
        appr_prod = 32'h0000_0200;
        prec_prod = 32'h0000_0100;
        for (int i = 0; i < 12; i++) begin
            in_valid  = (i % 2 == 0);
            start     = (i == 3);
            n_samples = (i == 3) ? 32'd9 : 32'd3;
            if (in_valid && in_ready) xfers++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("t3_xfers",  longint'(xfers),    3);
        chk("t3_rdy",    longint'(in_ready), 0);
        chk("t3_done",   longint'(done),     1);
        chk_sums("t3", 3, 3, 3, 0);

        // Square saturation: err = 2^24-1 per sample, err^2 exceeds 2^40
        do_start(4);
        for (int i = 0; i < 4; i++) send(32'h7FFF_FF00, 32'h8000_0000);
        cycles(2);
        chk("t4_done", longint'(done), 1);
        chk_sums("t4", 64'd67108860, 64'hFF_FFFF_FFFF, 64'd33554432, 0);

        // Asynchronous reset mid-run
        do_start(6);
        send(32'h0000_0300, 32'h0000_0100);
        send(32'h0000_0300, 32'h0000_0100);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy",  longint'(busy),     0);
        chk("t5_rdy",   longint'(in_ready), 0);
        chk("t5_done",  longint'(done),     0);
        chk_sums("t5_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);
        chk("t5_idle_busy", longint'(busy), 0);
        do_start(1);
        send(32'h0000_0100, 32'h0000_0100);
        cycles(2);
        chk("t5_done2", longint'(done), 1);
        chk_sums("t5_rerun", 0, 0, 1, 1);

`ifdef ERR_MAX_TRACK_EN
        do_start(3);
        send(32'h0000_0300, 32'h0000_0000);
        send(32'hFFFF_F900, 32'h0000_0000);
        send(32'h0000_0500, 32'h0000_0000);
        cycles(2);
        chk("t6_done", longint'(done),        1);
        chk("t6_max",  longint'(max_abs_err), 7);
        chk("t6_sum",  longint'($signed(sum_err)), 1);
        do_start(0);
        chk("t6_clr",  longint'(max_abs_err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
